// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data interface: one byte-masked read/write at a time on a word array.
// Latency: accept in cycle T, data_ok pulse in cycle T+LATENCY+1; at most one request per LATENCY+2 cycles.
// Backpressure: addr_ok only in IDLE; stall holds the CPU from accept until the data_ok beat.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_i, wr_i          request strobe and direction (1 = write), sampled at accept
//   addr_i               byte address; word index = addr_i[ADDR_W+1:2]
//   wstrb_i, wdata_i     byte enables and lane-aligned write data
//   addr_ok_o            request accepted this cycle (combinational)
//   data_ok_o            one-cycle response pulse (registered)
//   rdata_o              read data, held until the next read completes
//   stall_o              CPU must hold its pipeline (combinational)
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        wr_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic        addr_ok_o,
    output logic        data_ok_o,
    output logic [31:0] rdata_o,
    output logic        stall_o
);

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT4  = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [3:0]          strb_q;
    logic [31:0]         wdata_q;
    logic                data_ok_q;
    logic [31:0]         rdata_q;

    logic [31:0]         mem_q [0:DEPTH-1];

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    // The spare encoding behaves exactly like IDLE.
    logic is_idle;
    assign is_idle = (state_q != S_WAIT) && (state_q != S_RESP);

    logic accept;
    assign accept = is_idle && req_i;

    // With zero latency the access happens on the accept edge using the live
    // inputs; otherwise it uses the request captured at accept.
    logic              do_access;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_strb;
    logic [31:0]       acc_wdata;

    always_comb begin
        do_access = (accept && (LATENCY == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd1));
        acc_wr    = wr_q;
        acc_idx   = idx_q;
        acc_strb  = strb_q;
        acc_wdata = wdata_q;
        if (is_idle) begin
            acc_wr    = wr_i;
            acc_idx   = addr_i[ADDR_W+1:2];
            acc_strb  = wstrb_i;
            acc_wdata = wdata_i;
        end
    end

    // Array is never cleared; a reset on the access edge drops the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_access && acc_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_strb[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            strb_q    <= 4'd0;
            wdata_q   <= 32'd0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'd0;
        end else begin
            data_ok_q <= 1'b0;
            if (do_access && !acc_wr) begin
                rdata_q <= mem_q[acc_idx];
            end
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q   <= S_RESP;
                        data_ok_q <= 1'b1;
                        cnt_q     <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    if (req_i) begin
                        wr_q    <= wr_i;
                        idx_q   <= addr_i[ADDR_W+1:2];
                        strb_q  <= wstrb_i;
                        wdata_q <= wdata_i;
                        cnt_q   <= LAT4;
                        if (LATENCY == 0) begin
                            state_q   <= S_RESP;
                            data_ok_q <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
            endcase
        end
    end

    assign addr_ok_o = accept;
    assign stall_o   = accept || (state_q == S_WAIT);
    assign data_ok_o = data_ok_q;
    assign rdata_o   = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance driven from a
// vector table plus hand sequences, and a LATENCY=0 instance for throughput.
module tb_dmem_responder;

    logic        clk;
    logic        rst;

    // LATENCY=2 instance
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    logic        addr_ok, data_ok, stall;
    logic [31:0] rdata;

    // LATENCY=0 instance
    logic        req0, wr0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  strb0;
    logic        addr_ok0, data_ok0, stall0;
    logic [31:0] rdata0;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] last_rd  = 32'd0;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .wr_i(wr), .addr_i(addr),
        .wstrb_i(strb), .wdata_i(wdata), .addr_ok_o(addr_ok), .data_ok_o(data_ok),
        .rdata_o(rdata), .stall_o(stall)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req0), .wr_i(wr0), .addr_i(addr0),
        .wstrb_i(strb0), .wdata_i(wdata0), .addr_ok_o(addr_ok0), .data_ok_o(data_ok0),
        .rdata_o(rdata0), .stall_o(stall0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;   // expected rdata for reads
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One full transaction on the LATENCY=2 instance with cycle-exact checks.
    // Inputs are scrambled after accept to show they are ignored.
    task automatic txn(input int id, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; strb = s; wdata = d;
        #1;
        chk($sformatf("v%0d addr_ok@T", id), {31'd0, addr_ok}, 32'd1);
        chk($sformatf("v%0d stall@T", id),   {31'd0, stall},   32'd1);
        chk($sformatf("v%0d data_ok@T", id), {31'd0, data_ok}, 32'd0);
        @(negedge clk);
        req = 1'b0; wr = ~w; addr = ~a; strb = ~s; wdata = ~d;
        #1;
        chk($sformatf("v%0d stall@T+1", id),   {31'd0, stall},   32'd1);
        chk($sformatf("v%0d addr_ok@T+1", id), {31'd0, addr_ok}, 32'd0);
        chk($sformatf("v%0d data_ok@T+1", id), {31'd0, data_ok}, 32'd0);
        @(negedge clk); #1;
        chk($sformatf("v%0d stall@T+2", id),   {31'd0, stall},   32'd1);
        chk($sformatf("v%0d data_ok@T+2", id), {31'd0, data_ok}, 32'd0);
        @(negedge clk); #1;
        chk($sformatf("v%0d data_ok@T+3", id), {31'd0, data_ok}, 32'd1);
        chk($sformatf("v%0d stall@T+3", id),   {31'd0, stall},   32'd0);
        if (!w) last_rd = exp;
        chk($sformatf("v%0d rdata", id), rdata, last_rd);
        @(negedge clk); #1;
        chk($sformatf("v%0d data_ok@T+4", id), {31'd0, data_ok}, 32'd0);
        wr = 1'b0; addr = 32'd0; strb = 4'd0; wdata = 32'd0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_1000, 4'hF, 32'h1234_5678, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_0000, 4'h0, 32'h0,         32'h1234_5678};
        vecs[7]  = '{1'b1, 32'h0000_0024, 4'hF, 32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0024, 4'h0, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0027, 4'h0, 32'h0,         32'hCAFE_F00D};
        vecs[10] = '{1'b1, 32'h0000_0040, 4'hF, 32'h0102_0304, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0044, 4'hF, 32'h0A0B_0C0D, 32'h0};
        vecs[12] = '{1'b1, 32'h0000_0080, 4'hF, 32'h0000_0000, 32'h0};

        rst = 1'b1;
        req = 1'b0; wr = 1'b0; addr = 32'd0; strb = 4'd0; wdata = 32'd0;
        req0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; strb0 = 4'd0; wdata0 = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst data_ok", {31'd0, data_ok}, 32'd0);
        chk("rst rdata",   rdata,            32'd0);
        chk("rst stall",   {31'd0, stall},   32'd0);
        chk("rst addr_ok", {31'd0, addr_ok}, 32'd0);
        chk("rst rdata0",  rdata0,           32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven transactions
        for (int i = 0; i < 13; i++) begin
            txn(i, vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].exp);
        end

        // Single-cycle req at 0x40, address moves to 0x44 (as a write) during WAIT.
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 32'h40; #1;
        chk("pulse addr_ok", {31'd0, addr_ok}, 32'd1);
        @(negedge clk);
        req = 1'b0; wr = 1'b1; addr = 32'h44; strb = 4'hF; wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk); #1;
        chk("pulse data_ok", {31'd0, data_ok}, 32'd1);
        chk("pulse rdata",   rdata,            32'h0102_0304);
        last_rd = 32'h0102_0304;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk($sformatf("pulse no_resp%0d", k), {31'd0, data_ok}, 32'd0);
            chk($sformatf("pulse no_acc%0d", k),  {31'd0, addr_ok}, 32'd0);
        end
        wr = 1'b0; addr = 32'd0; strb = 4'd0; wdata = 32'd0;
        txn(20, 1'b0, 32'h44, 4'h0, 32'h0, 32'h0A0B_0C0D);

        // Reset during WAIT of a write: the write is dropped, no response.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 32'h80; strb = 4'hF; wdata = 32'h5A5A_5A5A;
        @(negedge clk);
        req = 1'b0; rst = 1'b1; #1;
        chk("rstmid stall in WAIT", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        chk("rstmid stall",   {31'd0, stall},   32'd0);
        chk("rstmid data_ok", {31'd0, data_ok}, 32'd0);
        chk("rstmid rdata",   rdata,            32'd0);
        rst = 1'b0;
        last_rd = 32'd0;
        @(negedge clk); #1;
        chk("rstmid data_ok late", {31'd0, data_ok}, 32'd0);
        wr = 1'b0; addr = 32'd0; strb = 4'd0; wdata = 32'd0;
        txn(21, 1'b0, 32'h80, 4'h0, 32'h0, 32'h0000_0000);
        txn(22, 1'b0, 32'h24, 4'h0, 32'h0, 32'hCAFE_F00D);

        // LATENCY=0 instance: write, then req held high for back-to-back reads.
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h8; strb0 = 4'hF; wdata0 = 32'h55AA_55AA; #1;
        chk("l0 wr addr_ok", {31'd0, addr_ok0}, 32'd1);
        chk("l0 wr stall",   {31'd0, stall0},   32'd1);
        @(negedge clk);
        req0 = 1'b0; #1;
        chk("l0 wr data_ok", {31'd0, data_ok0}, 32'd1);
        chk("l0 wr stall1",  {31'd0, stall0},   32'd0);
        chk("l0 wr rdata",   rdata0,            32'd0);
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b0; #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge clk); #1;
            end
            chk($sformatf("l0 k%0d addr_ok", k), {31'd0, addr_ok0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("l0 k%0d data_ok", k), {31'd0, data_ok0}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("l0 k%0d stall", k),   {31'd0, stall0},   (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 1) chk($sformatf("l0 k%0d rdata", k), rdata0, 32'h55AA_55AA);
        end
        req0 = 1'b0;
        @(negedge clk); #1;
        chk("l0 end data_ok", {31'd0, data_ok0}, 32'd0);
        chk("l0 end addr_ok", {31'd0, addr_ok0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
